// File: rtl/wb_regfile.sv
// Write-back stage of the miniRV pipeline. It selects the write-back value,
// commits it to the 32x32 register file, serves two bypassed ID read ports,
// counts retired instructions and drives the trace port.
module wb_regfile #(
  parameter int unsigned RF_DEPTH = 32,
  parameter int unsigned CNT_W    = 64
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              wb_valid,
  input  logic              rf_we_WB_in,
  input  logic [1:0]        rf_wsel_WB_in,
  input  logic [4:0]        wR_WB_in,
  input  logic [31:0]       ALU_C_WB_in,
  input  logic [31:0]       rdo_WB_in,
  input  logic [31:0]       pc4_WB_in,
  input  logic [31:0]       ext_WB_in,
  input  logic [31:0]       pc_WB_in,
  input  logic [4:0]        rR1,
  input  logic [4:0]        rR2,
  output logic [31:0]       rD1,
  output logic [31:0]       rD2,
  output logic [31:0]       wb_wD,
  output logic              wb_commit,
  output logic [CNT_W-1:0]  instret,
  output logic              debug_wb_have_inst,
  output logic [31:0]       debug_wb_pc,
  output logic              debug_wb_ena,
  output logic [4:0]        debug_wb_reg,
  output logic [31:0]       debug_wb_value
);

  localparam int unsigned XLEN = 32;

  // Entry 0 is never written (commit excludes x0) so it stays at its reset zero.
  logic [XLEN-1:0]  regs_q [RF_DEPTH];
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  // Write-back data select; unknown/unused encodings fall back to the ALU result.
  always_comb begin
    wb_wD = ALU_C_WB_in;
    case (rf_wsel_WB_in)
      2'b01:   wb_wD = rdo_WB_in;
      2'b10:   wb_wD = pc4_WB_in;
      2'b11:   wb_wD = ext_WB_in;
      default: wb_wD = ALU_C_WB_in;
    endcase
  end

  // A write lands only for a real instruction targeting a non-zero register outside reset.
  assign wb_commit = wb_valid & rf_we_WB_in & (wR_WB_in != 5'd0) & ~cpu_rst;

  // Read port 1: x0 is zero, a same-cycle commit to the same index is bypassed.
  always_comb begin
    rD1 = regs_q[rR1];
    if (rR1 == 5'd0) begin
      rD1 = '0;
    end else if (wb_commit && (rR1 == wR_WB_in)) begin
      rD1 = wb_wD;
    end
  end

  // Read port 2: same rules as port 1, independent of it.
  always_comb begin
    rD2 = regs_q[rR2];
    if (rR2 == 5'd0) begin
      rD2 = '0;
    end else if (wb_commit && (rR2 == wR_WB_in)) begin
      rD2 = wb_wD;
    end
  end

  // Register file storage with asynchronous clear.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int i = 0; i < int'(RF_DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_commit) begin
      regs_q[wR_WB_in] <= wb_wD;
    end
  end

  // Retired-instruction count: every valid WB slot counts, writes or not; wraps freely.
  always_comb begin
    instret_d = instret_q;
    if (wb_valid) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

  // Trace port mirrors the WB slot; have_inst is held low while in reset.
  assign debug_wb_have_inst = wb_valid & ~cpu_rst;
  assign debug_wb_pc        = pc_WB_in;
  assign debug_wb_ena       = wb_commit;
  assign debug_wb_reg       = wR_WB_in;
  assign debug_wb_value     = wb_wD;

endmodule
